// File: rtl/sccomp_dataflow.sv
// Single-cycle MIPS32 computer: CPU core, combinational-read instruction
// memory and combinational-read / synchronous-write data memory.
// rstn is active-high despite its name and resets the CPU asynchronously.

// Instruction memory: word-addressed from 0x00400000. The write port is tied
// off at the top level; contents are normally preloaded through mem.
module imem #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(DEPTH)-1:0]      waddr,
  input  logic [31:0]                   wdata,
  input  logic [31:0]                   addr,
  output logic [31:0]                   rdata
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   mem [0:DEPTH-1];
  logic [AW-1:0] idx;

  assign idx   = AW'((addr - 32'h0040_0000) >> 2);
  assign rdata = mem[idx];

  // Optional load port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
endmodule

// Data memory: word-addressed from 0x10010000, low two address bits ignored.
// Contents survive reset; writes are suppressed while reset is held.
module dmem #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   mem [0:DEPTH-1];
  logic [AW-1:0] idx;

  assign idx   = AW'((addr - 32'h1001_0000) >> 2);
  assign rdata = mem[idx];

  // Store on the rising edge unless reset is asserted
  always_ff @(posedge clk) begin
    if (we && !rst) mem[idx] <= wdata;
  end
endmodule

// 32 x 32 register file, two combinational read ports, one write port.
// $0 is cleared by reset and never written, so it always reads zero.
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] array_reg [0:31];

  assign rdata1 = array_reg[raddr1];
  assign rdata2 = array_reg[raddr2];

  // Asynchronous clear of all registers, otherwise write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) array_reg[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      array_reg[waddr] <= wdata;
    end
  end
endmodule

// Single-cycle CPU core: decode, ALU, branch/jump resolution and write-back
// all happen combinationally within the cycle.
module sccpu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic [31:0] pc,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] imm_s, imm_z, pc4, a, b;
  logic [31:0] next_pc, wb_data;
  logic [4:0]  wb_addr;
  logic        wb_en;

  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  assign target = instr[25:0];
  assign imm_s  = {{16{imm[15]}}, imm};
  assign imm_z  = {16'h0000, imm};
  assign pc4    = pc + 32'd4;

  assign dmem_addr  = a + imm_s;
  assign dmem_wdata = b;

  regfile cpu_ref (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (a),
    .rdata2 (b)
  );

  // Program counter with asynchronous restart vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= 32'h0040_0000;
    else     pc <= next_pc;
  end

  // Decode and execute; anything unrecognised falls through as a NOP
  always_comb begin
    next_pc = pc4;
    wb_en   = 1'b0;
    wb_addr = rd;
    wb_data = '0;
    dmem_we = 1'b0;
    case (op)
      6'h00: begin
        wb_en = 1'b1;
        case (funct)
          6'h00: wb_data = b << shamt;
          6'h02: wb_data = b >> shamt;
          6'h03: wb_data = $signed(b) >>> shamt;
          6'h04: wb_data = b << a[4:0];
          6'h06: wb_data = b >> a[4:0];
          6'h07: wb_data = $signed(b) >>> a[4:0];
          6'h08: begin
            wb_en   = 1'b0;
            next_pc = a;
          end
          6'h20, 6'h21: wb_data = a + b;
          6'h22, 6'h23: wb_data = a - b;
          6'h24: wb_data = a & b;
          6'h25: wb_data = a | b;
          6'h26: wb_data = a ^ b;
          6'h27: wb_data = ~(a | b);
          6'h2a: wb_data = {31'd0, $signed(a) < $signed(b)};
          6'h2b: wb_data = {31'd0, a < b};
          default: wb_en = 1'b0;
        endcase
      end
      6'h02: next_pc = {pc4[31:28], target, 2'b00};
      6'h03: begin
        next_pc = {pc4[31:28], target, 2'b00};
        wb_en   = 1'b1;
        wb_addr = 5'd31;
        wb_data = pc4;
      end
      6'h04: if (a == b) next_pc = pc4 + {imm_s[29:0], 2'b00};
      6'h05: if (a != b) next_pc = pc4 + {imm_s[29:0], 2'b00};
      6'h08, 6'h09: begin
        wb_en = 1'b1; wb_addr = rt; wb_data = a + imm_s;
      end
      6'h0a: begin
        wb_en = 1'b1; wb_addr = rt; wb_data = {31'd0, $signed(a) < $signed(imm_s)};
      end
      6'h0b: begin
        wb_en = 1'b1; wb_addr = rt; wb_data = {31'd0, a < imm_s};
      end
      6'h0c: begin
        wb_en = 1'b1; wb_addr = rt; wb_data = a & imm_z;
      end
      6'h0d: begin
        wb_en = 1'b1; wb_addr = rt; wb_data = a | imm_z;
      end
      6'h0e: begin
        wb_en = 1'b1; wb_addr = rt; wb_data = a ^ imm_z;
      end
      6'h0f: begin
        wb_en = 1'b1; wb_addr = rt; wb_data = {imm, 16'h0000};
      end
      6'h23: begin
        wb_en = 1'b1; wb_addr = rt; wb_data = dmem_rdata;
      end
      6'h2b: dmem_we = 1'b1;
      default: ;
    endcase
  end
endmodule

// Top level: CPU plus both memories
module sccomp_dataflow #(
  parameter int unsigned IMEM_WORDS = 1024,
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] instr_addr_read,
  output logic [31:0] instruction
);
  logic        dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

  sccpu sccpu (
    .clk        (clk),
    .rst        (rstn),
    .instr      (instruction),
    .pc         (instr_addr_read),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata)
  );

  imem #(.DEPTH(IMEM_WORDS)) imem_inst (
    .clk   (clk),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .addr  (instr_addr_read),
    .rdata (instruction)
  );

  dmem #(.DEPTH(DMEM_WORDS)) dmem_inst (
    .clk   (clk),
    .rst   (rstn),
    .we    (dmem_we),
    .addr  (dmem_addr),
    .wdata (dmem_wdata),
    .rdata (dmem_rdata)
  );
endmodule

// File: tb/tb_sccomp_dataflow.sv
// Bench for sccomp_dataflow: runs a short MIPS program from a vector table,
// checking fetch, register write-back and next PC every instruction, then
// exercises mid-run reset and DMEM retention across reset.
module tb_sccomp_dataflow;
  logic        clk;
  logic        rstn;
  logic [31:0] instr_addr_read;
  logic [31:0] instruction;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int unsigned reg_idx;
    logic [31:0] reg_val;
    logic [31:0] next_pc;
  } vec_t;

  localparam int unsigned NV = 22;
  vec_t vecs [NV];
  vec_t sb [$];

  sccomp_dataflow #(.IMEM_WORDS(1024), .DMEM_WORDS(1024)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .instr_addr_read (instr_addr_read),
    .instruction     (instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %08h required %08h", name, act, exp);
    end
  endtask

  function automatic int unsigned nonzero_regs();
    int unsigned n = 0;
    for (int r = 0; r < 32; r++)
      if (dut.sccpu.cpu_ref.array_reg[r] !== 32'h0) n++;
    return n;
  endfunction

  initial begin
    vec_t v;
    vecs[0]  = '{32'h00400000, 32'h20010005,  1, 32'h00000005, 32'h00400004}; // addi $1,$0,5
    vecs[1]  = '{32'h00400004, 32'h3C021001,  2, 32'h10010000, 32'h00400008}; // lui
    vecs[2]  = '{32'h00400008, 32'h34420010,  2, 32'h10010010, 32'h0040000C}; // ori
    vecs[3]  = '{32'h0040000C, 32'hAC410000,  1, 32'h00000005, 32'h00400010}; // sw
    vecs[4]  = '{32'h00400010, 32'h8C430000,  3, 32'h00000005, 32'h00400014}; // lw
    vecs[5]  = '{32'h00400014, 32'h2004FFFF,  4, 32'hFFFFFFFF, 32'h00400018}; // addi -1
    vecs[6]  = '{32'h00400018, 32'h0004282B,  5, 32'h00000001, 32'h0040001C}; // sltu
    vecs[7]  = '{32'h0040001C, 32'h0004302A,  6, 32'h00000000, 32'h00400020}; // slt
    vecs[8]  = '{32'h00400020, 32'h00043903,  7, 32'hFFFFFFFF, 32'h00400024}; // sra
    vecs[9]  = '{32'h00400024, 32'h20000007,  0, 32'h00000000, 32'h00400028}; // addi $0
    vecs[10] = '{32'h00400028, 32'h10000002,  0, 32'h00000000, 32'h00400034}; // beq taken
    vecs[11] = '{32'h00400034, 32'h14000005,  0, 32'h00000000, 32'h00400038}; // bne not taken
    vecs[12] = '{32'h00400038, 32'h0C100040, 31, 32'h0040003C, 32'h00400100}; // jal
    vecs[13] = '{32'h00400100, 32'h00244820,  9, 32'h00000004, 32'h00400104}; // add
    vecs[14] = '{32'h00400104, 32'h03E00008, 31, 32'h0040003C, 32'h0040003C}; // jr
    vecs[15] = '{32'h0040003C, 32'h000150C0, 10, 32'h00000028, 32'h00400040}; // sll
    vecs[16] = '{32'h00400040, 32'h00245806, 11, 32'h07FFFFFF, 32'h00400044}; // srlv
    vecs[17] = '{32'h00400044, 32'h00016022, 12, 32'hFFFFFFFB, 32'h00400048}; // sub
    vecs[18] = '{32'h00400048, 32'h388D00F0, 13, 32'hFFFFFF0F, 32'h0040004C}; // xori
    vecs[19] = '{32'h0040004C, 32'h2C0EFFFF, 14, 32'h00000001, 32'h00400050}; // sltiu
    vecs[20] = '{32'h00400050, 32'hFC000000,  1, 32'h00000005, 32'h00400054}; // undefined
    vecs[21] = '{32'h00400054, 32'h08100015,  1, 32'h00000005, 32'h00400054}; // j self

    for (int i = 0; i < 1024; i++) dut.imem_inst.mem[i] = '0;
    for (int i = 0; i < NV; i++) dut.imem_inst.mem[(vecs[i].pc - 32'h00400000) >> 2] = vecs[i].instr;
    dut.imem_inst.mem[11] = 32'h20080099; // skipped by beq
    dut.imem_inst.mem[12] = 32'h20080099;

    rstn = 1'b0;
    #1 rstn = 1'b1;
    #1;
    check("reset_pc", instr_addr_read, 32'h00400000);
    check("reset_regs_nonzero", nonzero_regs(), 32'd0);

    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    for (int i = 0; i < NV; i++) begin
      #1;
      check($sformatf("fetch_pc[%0d]", i), instr_addr_read, vecs[i].pc);
      check($sformatf("fetch_instr[%0d]", i), instruction, vecs[i].instr);
      sb.push_back(vecs[i]);
      @(negedge clk);
      v = sb.pop_front();
      check($sformatf("reg%0d[%0d]", v.reg_idx, i),
            dut.sccpu.cpu_ref.array_reg[v.reg_idx], v.reg_val);
      check($sformatf("next_pc[%0d]", i), instr_addr_read, v.next_pc);
    end

    check("skipped_reg8", dut.sccpu.cpu_ref.array_reg[8], 32'h0);
    check("dmem_word4", dut.dmem_inst.mem[4], 32'h00000005);

    // Mid-run reset takes effect without a clock edge
    #2 rstn = 1'b1;
    #1;
    check("midreset_pc", instr_addr_read, 32'h00400000);
    check("midreset_regs_nonzero", nonzero_regs(), 32'd0);

    // DMEM survives reset: reload $2 and read back the earlier store
    dut.imem_inst.mem[0] = 32'h3C021001; // lui $2,0x1001
    dut.imem_inst.mem[1] = 32'h8C430010; // lw $3,16($2)
    repeat (2) @(negedge clk);
    check("held_reset_pc", instr_addr_read, 32'h00400000);
    check("held_reset_reg2", dut.sccpu.cpu_ref.array_reg[2], 32'h0);
    rstn = 1'b0;
    @(negedge clk);
    check("restart_reg2", dut.sccpu.cpu_ref.array_reg[2], 32'h10010000);
    @(negedge clk);
    check("restart_lw_reg3", dut.sccpu.cpu_ref.array_reg[3], 32'h00000005);
    check("restart_pc", instr_addr_read, 32'h00400008);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
